// File: rtl/prv32_mdu_pkg.sv
// prv32_mdu_pkg: shared definitions for the sequential RV32M unit.
// Holds funct3 op codes, FSM states, default XLEN and op decode helpers.
package prv32_mdu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        logic s;
        s = 1'b0;
        unique case (op)
            MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: s = 1'b1;
            default: s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        logic s;
        s = 1'b0;
        unique case (op)
            MDU_MULH, MDU_DIV, MDU_REM: s = 1'b1;
            default: s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/prv32_mdu_iter.sv
// prv32_mdu_iter: one combinational step of shift-add multiply or
// restoring divide. Ports: div_mode, acc (hi:lo), opnd, acc_next.
module prv32_mdu_iter
    import prv32_mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic                div_mode,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] rem_diff;
    logic          rem_ge;

    // Multiply: acc = {partial, multiplier}; add multiplicand on lsb,
    // then shift right keeping the carry.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
                   + (acc[0] ? {1'b0, opnd} : '0);

    // Divide: acc = {remainder, dividend}; shift left one bit and try
    // to subtract the divisor. The shifted remainder needs XLEN+1 bits.
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign rem_ge   = rem_sh >= {1'b0, opnd};
    assign rem_diff = rem_sh - {1'b0, opnd};

    always_comb begin
        acc_next = '0;
        if (div_mode) begin
            if (rem_ge)
                acc_next = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_next = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/prv32_mdu_seq.sv
// prv32_mdu_seq: multi-cycle RV32M mul/div with req/resp valid-ready.
// Ports: clk, rst, req_*, resp_*, busy; kill with PRV32_MDU_KILL_EN.
module prv32_mdu_seq
    import prv32_mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
`ifdef PRV32_MDU_KILL_EN
    ,
    input  logic            kill
`endif
);

    localparam int CW = $clog2(XLEN) + 1;

    mdu_state_t        state;
    mdu_state_t        state_next;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_next;
    logic [CW-1:0]     cnt_q;
    logic              kill_i;

`ifdef PRV32_MDU_KILL_EN
    assign kill_i = kill;
`else
    assign kill_i = 1'b0;
`endif

    logic            accept;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;
    logic            ovf;
    logic            fast;
    logic [XLEN-1:0] fast_val;

    assign req_ready  = (state == S_IDLE) & ~kill_i;
    assign resp_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign accept     = req_valid & req_ready;

    assign sa    = is_signed_a(req_op) & req_a[XLEN-1];
    assign sb    = is_signed_b(req_op) & req_b[XLEN-1];
    assign a_mag = sa ? -req_a : req_a;
    assign b_mag = sb ? -req_b : req_b;

    assign b_zero = (req_b == '0);
    assign ovf    = is_signed_b(req_op) & is_div(req_op)
                  & (req_a == {1'b1, {(XLEN-1){1'b0}}})
                  & (&req_b);
    assign fast   = is_div(req_op) & (b_zero | ovf);

    // Divide by zero: quotient all ones, remainder = a.
    // Signed overflow: quotient = a (most negative), remainder 0.
    always_comb begin
        fast_val = '0;
        if (b_zero)
            fast_val = is_rem(req_op) ? req_a : '1;
        else
            fast_val = is_rem(req_op) ? '0 : req_a;
    end

    prv32_mdu_iter #(.XLEN(XLEN)) u_iter (
        .div_mode (is_div(op_q)),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_next)
    );

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   dv;
    logic [XLEN-1:0]   dv_fix;
    logic [XLEN-1:0]   result;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign dv       = is_rem(op_q) ? acc_q[2*XLEN-1:XLEN]
                                   : acc_q[XLEN-1:0];
    assign dv_fix   = neg_q ? -dv : dv;

    always_comb begin
        result = '0;
        if (is_div(op_q))
            result = dv_fix;
        else if (op_q == MDU_MUL)
            result = prod_fix[XLEN-1:0];
        else
            result = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept)
                    state_next = fast ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (kill_i)
                    state_next = S_IDLE;
                else if (cnt_q == '0)
                    state_next = S_DONE;
            end
            S_DONE: begin
                if (kill_i || resp_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // XLEN iterations, then a dedicated cycle (counter at 0) registers
    // the sign fix-up so the negate is not chained after the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            resp_data <= '0;
        end else if (state == S_IDLE && accept) begin
            op_q   <= req_op;
            neg_q  <= is_rem(req_op) ? sa : (sa ^ sb);
            opnd_q <= is_div(req_op) ? b_mag : a_mag;
            acc_q  <= {{XLEN{1'b0}}, is_div(req_op) ? a_mag : b_mag};
            cnt_q  <= CW'(XLEN);
            if (fast)
                resp_data <= fast_val;
        end else if (state == S_CALC && !kill_i) begin
            if (cnt_q != '0) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q - 1'b1;
            end else begin
                resp_data <= result;
            end
        end
    end

endmodule
